// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters with a registered
// output stage producing sync, blank, pixel coordinates and line/frame strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        CNT_W < 1 || CNT_W > 30 ||
        H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_params
      $error("vga_timing_gen: illegal timing parameter set");
    end
  endgenerate

  // Back porch >= 1 keeps every sync end strictly below the total, so all
  // boundaries below fit in CNT_W bits.
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_line_start;
  logic             r_frame_start;

  logic w_h_last;
  logic w_v_last;
  logic w_hs_act;
  logic w_vs_act;
  logic w_blank;
  logic w_h_zero;
  logic w_v_zero;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_hs_act = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign w_vs_act = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign w_blank  = (r_h_cnt >= H_ACT) || (r_v_cnt >= V_ACT);
  assign w_h_zero = (r_h_cnt == '0);
  assign w_v_zero = (r_v_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_blank       <= 1'b1;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      // Outputs sample the pre-increment counter so they lag it by one clk.
      r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
      r_blank       <= w_blank;
      r_x           <= r_h_cnt;
      r_y           <= r_v_cnt;
      r_line_start  <= w_h_zero;
      r_frame_start <= w_h_zero && w_v_zero;
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
